uart_ctrl: RTL and testbench
============================

# uart_ctrl

Memory-mapped controller that sequences the UART receiver and transmitter datapaths and shares them with the CPU bus. It captures each byte completed by the receiver into an RX FIFO and feeds a TX FIFO into the transmitter one byte at a time. It also exposes status and control registers and raises a single level interrupt. It sits between the CPU peripheral bus and the `uart_rx`/`uart_tx` instances. `uart_rx` `ien` is tied low at top level; this block owns all interrupt generation.

## Interface
- `RX_DEPTH`, 16, RX FIFO entries; power of two, ≥2
- `TX_DEPTH`, 16, TX FIFO entries; power of two, ≥2
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `addr` in 2 — register select: 0 DATA, 1 STATUS, 2 CTRL, 3 RXCOUNT
- `we` in 1 — bus write strobe, one cycle per access
- `re` in 1 — bus read strobe, one cycle per access
- `wdata` in 8 — write data
- `rdata` out 8 — registered read data
- `rx_data` in 8 — byte from receiver
- `rx_valid` in 1 — receiver valid level; a new byte is signalled by its 0→1 transition
- `tx_data` out 8 — byte to transmitter
- `tx_start` out 1 — one-cycle start pulse to transmitter
- `tx_busy` in 1 — transmitter busy level
- `irq` out 1 — registered level interrupt

## Operation
- RX capture: `rx_valid` is registered each cycle; a rising edge (current 1, previous 0) pushes `rx_data` into the RX FIFO.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky `ovr` is set.
- DATA read (`re`, addr 0): pops RX FIFO head into `rdata`. When empty, `rdata`=0x00 and pointers are unchanged.
- DATA write (`we`, addr 0): pushes `wdata[7:0]` into the TX FIFO. When full, the write is dropped silently.
- STATUS read: bit0 `rx_ne`, bit1 `rx_full`, bit2 `ovr`, bit3 `tx_full`, bit4 `tx_idle` (TX FIFO empty and sequencer IDLE), bits7:5 = 0.
- STATUS write: writing 1 to bit2 clears `ovr`. Other bits are ignored.
- CTRL read/write: bit0 `rx_ie`, bit1 `tx_ie`, bit2 `lpbk` (only with macro, else reads 0). Other bits read 0.
- RXCOUNT read: RX FIFO occupancy, 0..RX_DEPTH, saturating at 8 bits.
- Reads of STATUS/CTRL/RXCOUNT have no side effects. `we` and `re` asserted together perform both.
- FIFO pointers are log2(DEPTH)+1 bits, so wrap-around is natural; full/empty are distinguished by the MSB.
- TX sequencer states:
  - IDLE: if TX FIFO is non-empty, pop the head into the `tx_data` register and go to START.
  - START: `tx_start`=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy`=0, then go to IDLE.
  - `tx_data` holds stable from START through WAIT_DONE.
- `irq` = (`rx_ie` & (`rx_ne` | `ovr`)) | (`tx_ie` & `tx_idle`), registered.

## Timing
- Reset values: `rdata`=0x00, `tx_data`=0x00, `tx_start`=0, `irq`=0. Sequencer IDLE, both FIFOs empty, CTRL=0, `ovr`=0, `rx_valid` history=1.
  - History resets to 1 so that a valid level already held at reset is not captured.
- Reset mid-frame aborts the sequencer immediately. In-flight FIFO contents are discarded.
- RX: a rising edge of `rx_valid` at cycle N is pushed at edge N+1. `rx_ne` is visible in STATUS read at N+1, and `irq` rises at N+2.
- Reads: `rdata` is valid the cycle after `re`. The pop takes effect at the same edge.
- Push and pop on the same cycle:
  - Full RX FIFO: succeeds with no overrun.
  - Empty RX FIFO: the pop returns 0x00 and the push is stored.
- TX: a write to an empty FIFO in IDLE gives `tx_start` 2 cycles after the `we` cycle. Back-to-back bytes are separated only by the transmitter's busy period plus 2 cycles.
- `tx_busy` never asserting leaves the sequencer in WAIT_BUSY; it is recoverable only by `rst`.

## Configuration
- `UART_CTRL_LOOPBACK_EN` defined:
  - CTRL bit2 `lpbk` is implemented.
  - When `lpbk`=1, the sequencer pops TX bytes and pushes them directly into the RX FIFO (IDLE→IDLE, one byte per cycle). `tx_start` stays 0.
  - Receiver rising edges are ignored while `lpbk`=1.
  - Overrun rules apply as for RX capture.
- Undefined: `lpbk` is absent, CTRL bit2 writes are ignored and read as 0, and no loopback path is synthesized.

## Test plan
- Reset, then read all four registers → DATA 0x00, STATUS 0x10, CTRL 0x00, RXCOUNT 0x00; `irq`=0, `tx_start`=0.
- `rx_ie`=1; pulse `rx_valid` 0→1 with `rx_data`=0x5A → `irq`=1 two cycles later, RXCOUNT=1. DATA read returns 0x5A, then `irq` falls.
- Inject 17 bytes 0x00..0x10 without reading (RX_DEPTH=16) → STATUS bit2 and bit1 set; reads return 0x00..0x0F and a 17th read gives 0x00. Write STATUS 0x04 clears `ovr`.
- Write 0x41, 0x42; model `tx_busy` high 10 cycles after each `tx_start` → exactly two `tx_start` pulses with `tx_data` 0x41 then 0x42. With `tx_ie`=1, `irq` asserts after the final `tx_busy` fall.
- With RX FIFO full, assert an RX edge and a DATA read on the same cycle → no overrun, RXCOUNT stays 16, FIFO order is preserved.
- With `UART_CTRL_LOOPBACK_EN`: CTRL=0x04, write 0xA5, 0x3C → DATA reads return 0xA5, 0x3C; `tx_start` never pulses.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped UART controller. Captures receiver bytes into an RX
// FIFO, drains a TX FIFO into the transmitter through a small sequencer,
// exposes DATA/STATUS/CTRL/RXCOUNT registers and a level interrupt.
// Optional macro UART_CTRL_LOOPBACK_EN adds CTRL.lpbk, a TX->RX FIFO loopback.
module uart_ctrl #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       irq
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} seq_state_t;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [RX_AW:0] rx_wr_q, rx_rd_q, rx_cnt;
  logic [TX_AW:0] tx_wr_q, tx_rd_q;
  logic         rx_valid_q, ovr_q, rx_ie_q, tx_ie_q, irq_q, irq_d, tx_start_q;
  logic [7:0]   rdata_q, rdata_d, tx_data_q, rx_cnt8, rx_push_data;
  seq_state_t   state_q;
  logic         rx_empty, rx_full, tx_empty, tx_full, tx_idle, lpbk;
  logic         rx_pop, rx_push_req, rx_push, tx_push, tx_pop;

  // FIFO flags: equal pointers mean empty, MSB-only difference means full
  assign rx_cnt   = rx_wr_q - rx_rd_q;
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_idle  = tx_empty && (state_q == S_IDLE);

  // RXCOUNT is occupancy clamped to the 8-bit register
  generate
    if (RX_AW + 1 <= 8) begin : g_cnt_narrow
      assign rx_cnt8 = 8'(rx_cnt);
    end else begin : g_cnt_wide
      assign rx_cnt8 = (rx_cnt > (RX_AW+1)'(255)) ? 8'hFF : 8'(rx_cnt);
    end
  endgenerate

  // Bus-side FIFO strobes; a DATA read of an empty FIFO moves nothing
  assign rx_pop  = re && (addr == 2'd0) && !rx_empty;
  assign tx_push = we && (addr == 2'd0) && !tx_full;
  assign tx_pop  = (state_q == S_IDLE) && !tx_empty;
  // A same-cycle pop makes room, so a push into a full FIFO still lands
  assign rx_push = rx_push_req && (!rx_full || rx_pop);

`ifdef UART_CTRL_LOOPBACK_EN
  logic lpbk_q;
  assign lpbk = lpbk_q;

  // RX FIFO source: TX head while looping back, receiver edges otherwise
  always_comb begin
    rx_push_req  = 1'b0;
    rx_push_data = rx_data;
    if (lpbk) begin
      rx_push_req  = tx_pop;
      rx_push_data = tx_mem[tx_rd_q[TX_AW-1:0]];
    end else begin
      rx_push_req  = rx_valid && !rx_valid_q;
    end
  end
`else
  assign lpbk         = 1'b0;
  assign rx_push_req  = rx_valid && !rx_valid_q;
  assign rx_push_data = rx_data;
`endif

  // FIFO storage writes (no reset so the arrays map onto block RAM)
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_push_data;
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= wdata;
  end

  // FIFO pointers, receiver valid history and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_valid_q <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      // A new overrun wins over a clear in the same cycle
      if (rx_push_req && !rx_push)
        ovr_q <= 1'b1;
      else if (we && (addr == 2'd1) && wdata[2])
        ovr_q <= 1'b0;
    end
  end

  // CTRL register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
`ifdef UART_CTRL_LOOPBACK_EN
      lpbk_q  <= 1'b0;
`endif
    end else if (we && (addr == 2'd2)) begin
      rx_ie_q <= wdata[0];
      tx_ie_q <= wdata[1];
`ifdef UART_CTRL_LOOPBACK_EN
      lpbk_q  <= wdata[2];
`endif
    end
  end

  // Read mux; rdata holds its last value when no read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (addr)
        2'd0:    rdata_d = rx_pop ? rx_mem[rx_rd_q[RX_AW-1:0]] : 8'h00;
        2'd1:    rdata_d = {3'b000, tx_idle, tx_full, ovr_q, rx_full, !rx_empty};
        2'd2:    rdata_d = {5'b00000, lpbk, tx_ie_q, rx_ie_q};
        default: rdata_d = rx_cnt8;
      endcase
    end
  end

  assign irq_d = (rx_ie_q && (!rx_empty || ovr_q)) || (tx_ie_q && tx_idle);

  // Registered read data and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // TX sequencer: hand one byte to the transmitter and track its busy window
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // In loopback the byte is popped straight into the RX FIFO instead
          if (tx_pop && !lpbk) begin
            tx_data_q  <= tx_mem[tx_rd_q[TX_AW-1:0]];
            tx_start_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START:     state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (tx_busy)  state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (!tx_busy) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: RX model queue, TX expected-byte queue, transmitter model.
module tb_uart_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr;
  logic       we, re;
  logic [7:0] wdata, rdata, rx_data, tx_data;
  logic       rx_valid, tx_start, tx_busy, irq;

  int n_checks = 0;
  int n_errors = 0;
  int n_tx_start = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp_q[$];
  bit         ovr_m = 1'b0;

  always #5 clk = ~clk;

  uart_ctrl #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_pop();
    if (rx_q.size() == 0) return 8'h00;
    return rx_q.pop_front();
  endfunction

  function automatic logic [7:0] exp_status(input bit tx_idle_m);
    return {3'b000, tx_idle_m, 1'b0, ovr_m, rx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    check(tag, rdata, exp);
  endtask

  task automatic read_data(input string tag);
    logic [7:0] e;
    e = model_pop();
    bus_read(2'd0, e, tag);
  endtask

  task automatic inject(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else ovr_m = 1'b1;
    tick();
  endtask

  // Transmitter model: busy for 10 cycles after each start pulse
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_tx_start++;
        if (tx_exp_q.size() == 0) check("tx_unexpected_start", 1, 0);
        else check("tx_data", tx_data, tx_exp_q.pop_front());
        @(posedge clk); #1;
        check("tx_start_width", tx_start, 0);
        tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit irq_in_busy;
    bit seen;
    rst = 1'b1; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_irq", irq, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_rdata", rdata, 0);
    bus_read(2'd0, 8'h00, "reset_data");
    bus_read(2'd1, 8'h10, "reset_status");
    bus_read(2'd2, 8'h00, "reset_ctrl");
    bus_read(2'd3, 8'h00, "reset_rxcount");

    // CTRL read-back; lpbk only exists with the loopback build
    bus_write(2'd2, 8'hFF);
`ifdef UART_CTRL_LOOPBACK_EN
    bus_read(2'd2, 8'h07, "ctrl_readback");
`else
    bus_read(2'd2, 8'h03, "ctrl_readback");
`endif

    // Single byte with RX interrupt
    bus_write(2'd2, 8'h01);
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_q.push_back(8'h5A);
    check("irq_n_plus_1", irq, 0);
    tick();
    rx_valid = 1'b0;
    check("irq_n_plus_2", irq, 1);
    bus_read(2'd3, 8'd1, "rxcount_one");
    read_data("data_5a");
    tick();
    check("irq_fall", irq, 0);

    // Overrun: 17 bytes into a 16-deep FIFO
    bus_write(2'd2, 8'h00);
    for (int i = 0; i <= 16; i++) inject(8'(i));
    bus_read(2'd1, exp_status(1'b1), "status_ovr_full");
    bus_read(2'd3, 8'd16, "rxcount_full");
    for (int i = 0; i < 17; i++) read_data($sformatf("drain_%0d", i));
    bus_write(2'd1, 8'h04);
    ovr_m = 1'b0;
    bus_read(2'd1, exp_status(1'b1), "status_ovr_clr");

    // Push and pop together on an empty FIFO: read 0x00, byte kept
    rx_data = 8'h33; rx_valid = 1'b1; addr = 2'd0; re = 1'b1;
    tick();
    re = 1'b0; rx_valid = 1'b0;
    check("empty_pushpop_rd", rdata, model_pop());
    rx_q.push_back(8'h33);
    read_data("empty_pushpop_byte");

    // Push and pop together on a full FIFO: no overrun, order kept
    for (int i = 0; i < DEPTH; i++) inject(8'h80 + 8'(i));
    rx_data = 8'h90; rx_valid = 1'b1; addr = 2'd0; re = 1'b1;
    tick();
    re = 1'b0; rx_valid = 1'b0;
    check("full_pushpop_rd", rdata, model_pop());
    rx_q.push_back(8'h90);
    tick();
    bus_read(2'd1, exp_status(1'b1), "full_pushpop_status");
    bus_read(2'd3, 8'd16, "full_pushpop_count");
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("full_order_%0d", i));

    // TX: two bytes, interrupt once everything has drained
    bus_write(2'd2, 8'h02);
    tx_exp_q.push_back(8'h41);
    bus_write(2'd0, 8'h41);
    tx_exp_q.push_back(8'h42);
    bus_write(2'd0, 8'h42);
    check("tx_start_latency", tx_start, 1);
    irq_in_busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (tx_busy && irq) irq_in_busy = 1'b1;
      if (n_tx_start == 2 && !tx_busy && irq) seen = 1'b1;
    end
    check("tx_irq_after_done", seen, 1);
    check("tx_irq_low_while_busy", irq_in_busy, 0);
    check("tx_start_count", n_tx_start, 2);
    check("tx_queue_drained", tx_exp_q.size(), 0);

`ifdef UART_CTRL_LOOPBACK_EN
    // Loopback: bytes appear in RX FIFO, transmitter never started
    bus_write(2'd2, 8'h04);
    bus_write(2'd0, 8'hA5);
    bus_write(2'd0, 8'h3C);
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    repeat (4) tick();
    read_data("lpbk_a5");
    read_data("lpbk_3c");
    check("lpbk_no_start", n_tx_start, 2);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
